// File: rtl/feature_pkg.sv
// Shared constants and receiver FSM state for the feature SPI link.
package feature_pkg;

    localparam int NUM_BITS_X    = 11;
    localparam int NUM_BITS_Y    = 10;
    localparam int IMAGE_WIDTH   = 1280;
    localparam int IMAGE_HEIGHT  = 800;
    localparam int FEATURE_WIDTH = 2 * (NUM_BITS_X + NUM_BITS_Y);

    localparam int X_MIN_LSB = FEATURE_WIDTH - NUM_BITS_X;
    localparam int Y_MIN_LSB = X_MIN_LSB - NUM_BITS_Y;
    localparam int X_MAX_LSB = NUM_BITS_Y;
    localparam int Y_MAX_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PUSH,
        FRAME_END
    } rxState_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a write into a full FIFO is
// accepted when a read happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 42
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrEn,
    input  logic [WIDTH-1:0] wrData,
    input  logic             rdEn,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             doWrite;
    logic             doRead;

    assign empty   = (wrPtr == rdPtr);
    assign full    = (wrPtr[AW] != rdPtr[AW]) &&
                     (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doRead  = rdEn && !empty;
    assign doWrite = wrEn && (!full || doRead);
    assign rdData  = empty ? '0 : mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem[wrPtr[AW-1:0]] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + PTR_ONE;
            if (doRead)  rdPtr <= rdPtr + PTR_ONE;
        end
    end

endmodule

// File: rtl/feature_receive_spi.sv
// SPI slave deframing bounding-box feature words into a valid/ready stream.
// FEATURE_RX_BBOX_CHECK_EN adds box validation and malformed-word counters.
module feature_receive_spi #(
    parameter int NUM_BITS_X = feature_pkg::NUM_BITS_X,
    parameter int NUM_BITS_Y = feature_pkg::NUM_BITS_Y,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                 systemClock,
    input  logic                                 reset,
    input  logic                                 spiSck,
    input  logic                                 spiMosi,
    output logic                                 spiMiso,
    input  logic                                 spiTransferDone,
    output logic                                 featureValid,
    input  logic                                 featureReady,
    output logic [2*(NUM_BITS_X+NUM_BITS_Y)-1:0] featureVector,
    output logic                                 frameDone,
    output logic [15:0]                          frameFeatureCount,
    output logic                                 overflow,
`ifdef FEATURE_RX_BBOX_CHECK_EN
    output logic                                 partialWord,
    output logic [15:0]                          malformedCount,
    output logic [15:0]                          malformedLast
`else
    output logic                                 partialWord
`endif
);

    import feature_pkg::*;

    localparam int FW = 2 * (NUM_BITS_X + NUM_BITS_Y);
    localparam int CW = $clog2(FW + 1);
    localparam logic [CW-1:0] FW_CNT   = CW'(FW);
    localparam logic [CW-1:0] LAST_CNT = CW'(FW - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    rxState_t      state;
    rxState_t      nextState;
    logic [CW-1:0] bitCount;
    logic [FW-1:0] shiftReg;
    logic [15:0]   featCnt;
    logic          donePending;

    logic sckS1, sckS2, sckS3;
    logic mosiS1, mosiS2;
    logic doneS1, doneS2, doneS3;
    logic sckRise, sckFall, doneRise;
    logic endReq, wordPending;

    logic fifoWr, fifoRd, fifoFull, fifoEmpty;
    logic pushAccept, pushDrop, wordOk;

    assign sckRise     = sckS2 & ~sckS3;
    assign sckFall     = ~sckS2 & sckS3;
    assign doneRise    = doneS2 & ~doneS3;
    assign endReq      = doneRise | donePending;
    // A word finishing this cycle must be pushed before the frame closes.
    assign wordPending = (bitCount == FW_CNT) ||
                         (sckRise && bitCount == LAST_CNT);

    assign fifoRd       = featureValid & featureReady;
    assign pushDrop     = fifoWr & fifoFull & ~fifoRd;
    assign pushAccept   = fifoWr & ~pushDrop;
    assign featureValid = ~fifoEmpty;

    always_comb begin
        nextState = state;
        fifoWr    = 1'b0;
        frameDone = 1'b0;
        unique case (state)
            IDLE: begin
                if (endReq)       nextState = FRAME_END;
                else if (sckRise) nextState = SHIFT;
            end
            SHIFT: begin
                if (bitCount == FW_CNT)          nextState = PUSH;
                else if (endReq && !wordPending) nextState = FRAME_END;
            end
            PUSH: begin
                fifoWr    = wordOk;
                nextState = endReq ? FRAME_END : SHIFT;
            end
            FRAME_END: begin
                frameDone = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge systemClock) begin
        if (reset) begin
            state             <= IDLE;
            sckS1             <= 1'b0;
            sckS2             <= 1'b0;
            sckS3             <= 1'b0;
            mosiS1            <= 1'b0;
            mosiS2            <= 1'b0;
            doneS1            <= 1'b0;
            doneS2            <= 1'b0;
            doneS3            <= 1'b0;
            shiftReg          <= '0;
            bitCount          <= '0;
            featCnt           <= '0;
            donePending       <= 1'b0;
            overflow          <= 1'b0;
            spiMiso           <= 1'b0;
            frameFeatureCount <= '0;
            partialWord       <= 1'b0;
        end else begin
            state       <= nextState;
            sckS1       <= spiSck;
            sckS2       <= sckS1;
            sckS3       <= sckS2;
            mosiS1      <= spiMosi;
            mosiS2      <= mosiS1;
            doneS1      <= spiTransferDone;
            doneS2      <= doneS1;
            doneS3      <= doneS2;
            donePending <= endReq && state != FRAME_END &&
                           nextState != FRAME_END;

            if (sckRise) shiftReg <= {shiftReg[FW-2:0], mosiS2};

            if (state == PUSH || state == FRAME_END)
                bitCount <= sckRise ? CNT_ONE : '0;
            else if (sckRise)
                bitCount <= bitCount + CNT_ONE;

            // Miso only moves while sck is low so the master samples it cleanly.
            if (sckFall) spiMiso <= overflow;

            if (state == FRAME_END) begin
                frameFeatureCount <= featCnt;
                partialWord       <= (bitCount != '0);
                featCnt           <= '0;
                overflow          <= 1'b0;
            end else begin
                if (pushAccept && featCnt != 16'hFFFF)
                    featCnt <= featCnt + 16'd1;
                if (pushDrop) overflow <= 1'b1;
            end
        end
    end

`ifdef FEATURE_RX_BBOX_CHECK_EN
    logic [NUM_BITS_X-1:0] xMin, xMax;
    logic [NUM_BITS_Y-1:0] yMin, yMax;

    assign xMin = shiftReg[FW-1 -: NUM_BITS_X];
    assign yMin = shiftReg[FW-1-NUM_BITS_X -: NUM_BITS_Y];
    assign xMax = shiftReg[NUM_BITS_Y +: NUM_BITS_X];
    assign yMax = shiftReg[0 +: NUM_BITS_Y];

    assign wordOk = !(xMin > xMax || yMin > yMax ||
                      int'(xMax) >= IMAGE_WIDTH ||
                      int'(yMax) >= IMAGE_HEIGHT);

    always_ff @(posedge systemClock) begin
        if (reset) begin
            malformedCount <= '0;
            malformedLast  <= '0;
        end else if (state == FRAME_END) begin
            malformedLast  <= malformedCount;
            malformedCount <= '0;
        end else if (state == PUSH && !wordOk &&
                     malformedCount != 16'hFFFF) begin
            malformedCount <= malformedCount + 16'd1;
        end
    end
`else
    assign wordOk = 1'b1;
`endif

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) fifo (
        .clk    (systemClock),
        .reset  (reset),
        .wrEn   (fifoWr),
        .wrData (shiftReg),
        .rdEn   (fifoRd),
        .rdData (featureVector),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

endmodule

// File: tb/tb_feature_receive_spi.sv
// Frame-level bench for feature_receive_spi: vector table plus scoreboard.
`timescale 1ns/1ps
module tb_feature_receive_spi;

    localparam int FW = 42;
    localparam logic [FW-1:0] TEST1 = 42'h155_5555_5555;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic spiSck = 1'b0;
    logic spiMosi = 1'b0;
    logic spiTransferDone = 1'b0;
    logic featureReady = 1'b0;
    logic spiMiso, featureValid, frameDone, overflow, partialWord;
    logic [FW-1:0] featureVector;
    logic [15:0] frameFeatureCount;
`ifdef FEATURE_RX_BBOX_CHECK_EN
    logic [15:0] malformedCount, malformedLast;
`endif

    int checks = 0;
    int errors = 0;
    int frameDoneCount = 0;
    int expFrames = 0;
    int frameStored = 0;
    bit prevDone = 1'b0;
    logic [FW-1:0] expQ [$];

    always #5 clk = ~clk;

    feature_receive_spi dut (
        .systemClock       (clk),
        .reset             (reset),
        .spiSck            (spiSck),
        .spiMosi           (spiMosi),
        .spiMiso           (spiMiso),
        .spiTransferDone   (spiTransferDone),
        .featureValid      (featureValid),
        .featureReady      (featureReady),
        .featureVector     (featureVector),
        .frameDone         (frameDone),
        .frameFeatureCount (frameFeatureCount),
        .overflow          (overflow),
`ifdef FEATURE_RX_BBOX_CHECK_EN
        .partialWord       (partialWord),
        .malformedCount    (malformedCount),
        .malformedLast     (malformedLast)
`else
        .partialWord       (partialWord)
`endif
    );

    always @(negedge clk) begin
        if (!reset && featureValid && featureReady) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL pop: unexpected word %h", featureVector);
            end else begin
                logic [FW-1:0] e;
                e = expQ.pop_front();
                if (featureVector !== e) begin
                    errors++;
                    $display("FAIL pop: got %h expected %h", featureVector, e);
                end
            end
        end
        if (!reset && frameDone) begin
            frameDoneCount++;
            checks++;
            if (prevDone) begin
                errors++;
                $display("FAIL frameDoneWidth: got 2+ cycles expected 1");
            end
        end
        prevDone = frameDone;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit storeable(input logic [FW-1:0] w);
`ifdef FEATURE_RX_BBOX_CHECK_EN
        logic [10:0] x0, x1;
        logic [9:0] y0, y1;
        {x0, y0, x1, y1} = w;
        return !(x0 > x1 || y0 > y1 || x1 >= 11'd1280 || y1 >= 10'd800);
`else
        return (^w !== 1'bx);
`endif
    endfunction

    function automatic logic [FW-1:0] randWord();
        logic [10:0] x0, x1;
        logic [9:0] y0, y1;
        x0 = 11'($urandom_range(1279, 0));
        x1 = 11'($urandom_range(1279, int'(x0)));
        y0 = 10'($urandom_range(799, 0));
        y1 = 10'($urandom_range(799, int'(y0)));
        return {x0, y0, x1, y1};
    endfunction

    task automatic sendBits(input logic [FW-1:0] w, input int n,
                            input bit doneLast);
        for (int i = n - 1; i >= 0; i--) begin
            spiMosi = w[i];
            tick(4);
            spiSck = 1'b1;
            if (doneLast && i == 0) spiTransferDone = 1'b1;
            tick(4);
            spiSck = 1'b0;
            spiTransferDone = 1'b0;
        end
    endtask

    task automatic sendWord(input logic [FW-1:0] w, input bit doneLast);
        if (storeable(w) && expQ.size() < 16) begin
            expQ.push_back(w);
            frameStored++;
        end
        sendBits(w, FW, doneLast);
    endtask

    task automatic endFrame(input bit strobe, input int expCnt,
                            input bit expPart);
        if (strobe) begin
            spiTransferDone = 1'b1;
            tick(4);
            spiTransferDone = 1'b0;
        end
        expFrames++;
        for (int i = 0; i < 40 && frameDoneCount < expFrames; i++) tick(1);
        check("frameDoneSeen", 64'(frameDoneCount), 64'(expFrames));
        tick(2);
        check("frameFeatureCount", 64'(frameFeatureCount), 64'(expCnt));
        check("partialWord", 64'(partialWord), 64'(expPart));
        check("overflowCleared", 64'(overflow), 64'd0);
    endtask

    task automatic drain();
        featureReady = 1'b1;
        for (int i = 0; i < 400 && expQ.size() != 0; i++) tick(1);
        check("drainLeft", 64'(expQ.size()), 64'd0);
        tick(2);
        check("validAfterDrain", 64'(featureValid), 64'd0);
    endtask

    typedef struct {
        bit ready;
        int nWords;
        int tailBits;
        bit doneLast;
        bit fixedFirst;
        int expCount;
        bit expOvf;
        bit expPart;
    } row_t;

    row_t rows [6];
    logic [FW-1:0] w;
    logic [FW-1:0] w3;
    int expCnt;

    initial begin
        rows[0] = '{1'b1, 1,  0,  1'b0, 1'b1, 1,  1'b0, 1'b0};
        rows[1] = '{1'b0, 17, 0,  1'b0, 1'b0, 16, 1'b1, 1'b0};
        rows[2] = '{1'b1, 0,  20, 1'b0, 1'b0, 0,  1'b0, 1'b1};
        rows[3] = '{1'b1, 1,  0,  1'b0, 1'b0, 1,  1'b0, 1'b0};
        rows[4] = '{1'b1, 2,  0,  1'b1, 1'b0, 2,  1'b0, 1'b0};
        rows[5] = '{1'b1, 3,  5,  1'b0, 1'b0, 3,  1'b0, 1'b1};

        tick(3);
        check("rstValid", 64'(featureValid), 64'd0);
        check("rstVector", 64'(featureVector), 64'd0);
        check("rstFrameDone", 64'(frameDone), 64'd0);
        check("rstCount", 64'(frameFeatureCount), 64'd0);
        check("rstOverflow", 64'(overflow), 64'd0);
        check("rstPartial", 64'(partialWord), 64'd0);
        check("rstMiso", 64'(spiMiso), 64'd0);
        reset = 1'b0;
        tick(2);

        foreach (rows[r]) begin
            featureReady = rows[r].ready;
            frameStored = 0;
            for (int k = 0; k < rows[r].nWords; k++) begin
                w = (k == 0 && rows[r].fixedFirst) ? TEST1 : randWord();
                sendWord(w, rows[r].doneLast && k == rows[r].nWords - 1);
            end
            if (rows[r].tailBits > 0) sendBits(randWord(), rows[r].tailBits, 1'b0);
            tick(6);
            check($sformatf("row%0d spiMiso", r), 64'(spiMiso), 64'(rows[r].expOvf));
            check($sformatf("row%0d overflow", r), 64'(overflow), 64'(rows[r].expOvf));
`ifdef FEATURE_RX_BBOX_CHECK_EN
            expCnt = frameStored;
`else
            expCnt = rows[r].expCount;
`endif
            endFrame(!rows[r].doneLast, expCnt, rows[r].expPart);
            drain();
        end

        featureReady = 1'b0;
        sendWord(randWord(), 1'b0);
        sendWord(randWord(), 1'b0);
        w3 = randWord();
        sendBits(w3 >> 12, 30, 1'b0);
        tick(2);
        reset = 1'b1;
        tick(2);
        expQ.delete();
        reset = 1'b0;
        tick(1);
        check("midRstValid", 64'(featureValid), 64'd0);
        check("midRstVector", 64'(featureVector), 64'd0);
        check("midRstCount", 64'(frameFeatureCount), 64'd0);
        check("midRstPartial", 64'(partialWord), 64'd0);
        check("midRstMiso", 64'(spiMiso), 64'd0);
        sendBits(w3, 12, 1'b0);
        tick(6);
        endFrame(1'b1, 0, 1'b1);
        featureReady = 1'b1;
        sendWord(randWord(), 1'b0);
        sendWord(randWord(), 1'b0);
        tick(6);
        endFrame(1'b1, 2, 1'b0);
        drain();

`ifdef FEATURE_RX_BBOX_CHECK_EN
        featureReady = 1'b1;
        sendWord({11'd10, 10'd5, 11'd4, 10'd9}, 1'b0);
        sendWord({11'd4, 10'd5, 11'd10, 10'd9}, 1'b0);
        tick(6);
        check("bboxMalformedRunning", 64'(malformedCount), 64'd1);
        endFrame(1'b1, 1, 1'b0);
        check("bboxMalformedLast", 64'(malformedLast), 64'd1);
        check("bboxMalformedCleared", 64'(malformedCount), 64'd0);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
